// File: rtl/decode_bp_stage.sv
// RV32IM decode stage with 2-bit BHT branch prediction, encryption-hold FSM
// and an ID/EX pipeline register with flush > stall > load priority.
module decode_bp_stage #(
    parameter int         ADDRESS_BITS = 32,
    parameter int         BHT_DEPTH    = 64,
    parameter int         BHT_IDX      = $clog2(BHT_DEPTH),
    parameter logic [1:0] BHT_INIT     = 2'b01
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDRESS_BITS-1:0] pc_i,
    input  logic [31:0]             instr_i,
    input  logic                    instr_valid_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic                    out_of_loop_i,
    input  logic                    upd_valid_i,
    input  logic [ADDRESS_BITS-1:0] upd_pc_i,
    input  logic                    upd_taken_i,
    output logic                    redirect_o,
    output logic [ADDRESS_BITS-1:0] target_pc_o,
    output logic                    fetch_hold_o,
    output logic                    id_valid_o,
    output logic [6:0]              op_o,
    output logic [2:0]              funct3_o,
    output logic [6:0]              funct7_o,
    output logic [4:0]              rs1_o,
    output logic [4:0]              rs2_o,
    output logic [4:0]              rd_o,
    output logic                    wen_o,
    output logic [31:0]             imm32_o,
    output logic [ADDRESS_BITS-1:0] pc_o,
    output logic                    pred_taken_o,
    output logic                    jalr_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_ENC    = 7'b0001011;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        ENC_WAIT = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Raw instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign rd     = instr_i[11:7];

    logic is_jal;
    logic is_jalr;
    logic is_branch;
    logic is_enc;
    logic accept;
    logic wen_dec;
    logic [31:0] imm_dec;
    logic [ADDRESS_BITS-1:0] imm_addr;
    logic [ADDRESS_BITS-1:0] branch_target;
    logic pred_redirect;
    logic [ADDRESS_BITS-1:0] pred_target;

    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_enc    = (opcode == OP_ENC);

    // Only a fresh instruction in IDLE with no stall/flush is taken into ID/EX
    assign accept = instr_valid_i & ~stall_i & ~flush_i & (state_reg == IDLE);

    // Stores, branches and encryption ops never write a GPR; neither does rd=x0
    assign wen_dec = ~((opcode == OP_STORE) | is_branch | is_enc | (rd == 5'd0));

    // Immediate extraction per instruction format
    always_comb begin
        imm_dec = '0;
        case (opcode)
            OP_IMM: begin
                // Shift-immediates carry only a 5-bit shamt
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    imm_dec = {27'b0, instr_i[24:20]};
                else
                    imm_dec = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_LOAD, OP_JALR:
                imm_dec = {{20{instr_i[31]}}, instr_i[31:20]};
            OP_STORE:
                imm_dec = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OP_BRANCH:
                imm_dec = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
            OP_JAL:
                imm_dec = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_dec = {instr_i[31:12], 12'b0};
            default:
                imm_dec = '0;
        endcase
    end

    // Sign-adjust the immediate to the PC width; addition wraps naturally
    assign imm_addr      = ADDRESS_BITS'($signed(imm_dec));
    assign branch_target = pc_i + imm_addr;

    // Branch history table: one 2-bit saturating counter per entry
    logic [BHT_DEPTH-1:0][1:0] bht_reg;
    logic [BHT_DEPTH-1:0][1:0] bht_next;
    logic [BHT_IDX-1:0]        bht_rd_idx;
    logic [BHT_IDX-1:0]        bht_upd_idx;
    logic                      bht_pred_taken;

    assign bht_rd_idx     = pc_i[BHT_IDX+1:2];
    assign bht_upd_idx    = upd_pc_i[BHT_IDX+1:2];
    // Read uses the registered counter, so a same-cycle update is not visible
    assign bht_pred_taken = bht_reg[bht_rd_idx][1];

    // Upper PC bits of the training port do not take part in indexing
    logic unused_upd_pc;
    assign unused_upd_pc = ^upd_pc_i;

    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            logic       hit;
            logic [1:0] inc_val;
            logic [1:0] dec_val;
            assign hit     = upd_valid_i & (bht_upd_idx == BHT_IDX'(gi));
            assign inc_val = (bht_reg[gi] == 2'b11) ? 2'b11 : bht_reg[gi] + 2'd1;
            assign dec_val = (bht_reg[gi] == 2'b00) ? 2'b00 : bht_reg[gi] - 2'd1;
            assign bht_next[gi] = hit ? (upd_taken_i ? inc_val : dec_val) : bht_reg[gi];
        end
    endgenerate

    // BHT counter storage; survives flush, only reset reinitialises it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bht_reg <= {BHT_DEPTH{BHT_INIT}};
        else
            bht_reg <= bht_next;
    end

    // Next-fetch prediction: JAL always redirects, branches follow the BHT
    always_comb begin
        pred_redirect = 1'b0;
        pred_target   = '0;
        if (accept) begin
            if (is_jal) begin
                pred_redirect = 1'b1;
                pred_target   = branch_target;
            end else if (is_branch && bht_pred_taken) begin
                pred_redirect = 1'b1;
                pred_target   = branch_target;
            end
        end
    end

    assign redirect_o  = pred_redirect;
    assign target_pc_o = pred_target;

    // Encryption-hold FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Encryption-hold FSM next state: wait until the accelerator reports done
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && is_enc && !out_of_loop_i)
                    state_next = ENC_WAIT;
            end
            ENC_WAIT: begin
                if (out_of_loop_i || flush_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Hold is released in the same cycle the accelerator signals completion
    assign fetch_hold_o = ((state_reg == ENC_WAIT) & ~out_of_loop_i) | stall_i;

    // ID/EX pipeline register contents
    logic                    id_valid_reg;
    logic [6:0]              op_reg;
    logic [2:0]              funct3_reg;
    logic [6:0]              funct7_reg;
    logic [4:0]              rs1_reg;
    logic [4:0]              rs2_reg;
    logic [4:0]              rd_reg;
    logic                    wen_reg;
    logic [31:0]             imm32_reg;
    logic [ADDRESS_BITS-1:0] pc_reg;
    logic                    pred_taken_reg;
    logic                    jalr_reg;

    // ID/EX register: flush kills the entry, stall holds it, otherwise load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_reg   <= 1'b0;
            op_reg         <= '0;
            funct3_reg     <= '0;
            funct7_reg     <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            rd_reg         <= '0;
            wen_reg        <= 1'b0;
            imm32_reg      <= '0;
            pc_reg         <= '0;
            pred_taken_reg <= 1'b0;
            jalr_reg       <= 1'b0;
        end else if (flush_i) begin
            id_valid_reg   <= 1'b0;
        end else if (!stall_i) begin
            id_valid_reg   <= accept;
            op_reg         <= opcode;
            funct3_reg     <= funct3;
            funct7_reg     <= funct7;
            rs1_reg        <= rs1;
            rs2_reg        <= rs2;
            rd_reg         <= rd;
            wen_reg        <= wen_dec;
            imm32_reg      <= imm_dec;
            pc_reg         <= pc_i;
            pred_taken_reg <= pred_redirect;
            jalr_reg       <= accept & is_jalr;
        end
    end

    assign id_valid_o   = id_valid_reg;
    assign op_o         = op_reg;
    assign funct3_o     = funct3_reg;
    assign funct7_o     = funct7_reg;
    assign rs1_o        = rs1_reg;
    assign rs2_o        = rs2_reg;
    assign rd_o         = rd_reg;
    assign wen_o        = wen_reg;
    assign imm32_o      = imm32_reg;
    assign pc_o         = pc_reg;
    assign pred_taken_o = pred_taken_reg;
    assign jalr_o       = jalr_reg;

endmodule

// File: tb/tb_decode_bp_stage.sv
// Scoreboard bench for decode_bp_stage: directed scenarios followed by
// randomized traffic, checked against a behavioural model.
module tb_decode_bp_stage;

    localparam int AB    = 32;
    localparam int DEPTH = 64;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_ENC    = 7'b0001011;

    logic          clk;
    logic          rst_n;
    logic [AB-1:0] pc_i;
    logic [31:0]   instr_i;
    logic          instr_valid_i;
    logic          stall_i;
    logic          flush_i;
    logic          out_of_loop_i;
    logic          upd_valid_i;
    logic [AB-1:0] upd_pc_i;
    logic          upd_taken_i;
    logic          redirect_o;
    logic [AB-1:0] target_pc_o;
    logic          fetch_hold_o;
    logic          id_valid_o;
    logic [6:0]    op_o;
    logic [2:0]    funct3_o;
    logic [6:0]    funct7_o;
    logic [4:0]    rs1_o;
    logic [4:0]    rs2_o;
    logic [4:0]    rd_o;
    logic          wen_o;
    logic [31:0]   imm32_o;
    logic [AB-1:0] pc_o;
    logic          pred_taken_o;
    logic          jalr_o;

    decode_bp_stage #(
        .ADDRESS_BITS(AB),
        .BHT_DEPTH   (DEPTH),
        .BHT_INIT    (2'b01)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .instr_valid_i(instr_valid_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .out_of_loop_i(out_of_loop_i),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .redirect_o   (redirect_o),
        .target_pc_o  (target_pc_o),
        .fetch_hold_o (fetch_hold_o),
        .id_valid_o   (id_valid_o),
        .op_o         (op_o),
        .funct3_o     (funct3_o),
        .funct7_o     (funct7_o),
        .rs1_o        (rs1_o),
        .rs2_o        (rs2_o),
        .rd_o         (rd_o),
        .wen_o        (wen_o),
        .imm32_o      (imm32_o),
        .pc_o         (pc_o),
        .pred_taken_o (pred_taken_o),
        .jalr_o       (jalr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          redirect;
        logic [AB-1:0] target;
        logic          hold;
    } comb_t;

    typedef struct {
        bit            chk_all;
        logic          valid;
        logic [31:0]   instr;
        logic          wen;
        logic [31:0]   imm;
        logic [AB-1:0] pc;
        logic          pt;
        logic          jalr;
    } reg_t;

    comb_t comb_q[$];
    reg_t  reg_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int   bht[DEPTH];
    bit   in_enc;
    reg_t idex;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(logic [31:0] v, int bits);
        if (v[bits-1]) return v - (32'd1 << bits);
        return v;
    endfunction

    function automatic logic [31:0] ref_imm(logic [31:0] ins);
        logic [6:0]  op = ins[6:0];
        logic [2:0]  f3 = ins[14:12];
        logic [31:0] v;
        case (op)
            OP_IMM: begin
                if (f3 == 3'd1 || f3 == 3'd5) return 32'(ins[24:20]);
                return sx(32'(ins[31:20]), 12);
            end
            OP_LOAD, OP_JALR: return sx(32'(ins[31:20]), 12);
            OP_STORE: return sx(32'(ins[31:25]) * 32 + 32'(ins[11:7]), 12);
            OP_BRANCH: begin
                v = 32'(ins[31]) * 4096 + 32'(ins[7]) * 2048
                  + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
                return sx(v, 13);
            end
            OP_JAL: begin
                v = 32'(ins[31]) * (1 << 20) + 32'(ins[19:12]) * 4096
                  + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
                return sx(v, 21);
            end
            OP_LUI, OP_AUIPC: return 32'(ins[31:12]) * 4096;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] enc_j(int imm, logic [4:0] rd);
        logic [20:0] m = imm[20:0];
        return {m[20], m[10:1], m[11], m[19:12], rd, OP_JAL};
    endfunction

    function automatic logic [31:0] enc_b(int imm, logic [4:0] r1, logic [4:0] r2, logic [2:0] f3);
        logic [12:0] m = imm[12:0];
        return {m[12], m[10:5], r2, r1, f3, m[4:1], m[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] r1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) bht[i] = 1;
        in_enc = 0;
        idex   = '{chk_all: 1'b1, valid: 1'b0, instr: 32'd0, wen: 1'b0, imm: 32'd0,
                   pc: '0, pt: 1'b0, jalr: 1'b0};
    endtask

    // One clock cycle of stimulus; model predicts comb outputs now and
    // the ID/EX contents after the coming rising edge.
    task automatic step(bit rst, logic [31:0] ins, logic [AB-1:0] pc, bit v, bit st, bit fl,
                        bit ool, bit uv, logic [AB-1:0] upc, bit ut);
        comb_t c;
        bit    accept;
        int    idx;
        logic [6:0] op;
        @(negedge clk);
        rst_n         = !rst;
        instr_i       = ins;
        pc_i          = pc;
        instr_valid_i = v;
        stall_i       = st;
        flush_i       = fl;
        out_of_loop_i = ool;
        upd_valid_i   = uv;
        upd_pc_i      = upc;
        upd_taken_i   = ut;

        if (rst) model_reset();
        op     = ins[6:0];
        accept = v && !st && !fl && !in_enc;
        idx    = int'(pc[7:2]);
        c.redirect = 0;
        c.target   = '0;
        if (accept && (op == OP_JAL || (op == OP_BRANCH && bht[idx] >= 2))) begin
            c.redirect = 1;
            c.target   = pc + ref_imm(ins);
        end
        c.hold = (in_enc && !ool) || st;
        comb_q.push_back(c);

        if (rst) begin
            reg_q.push_back(idex);
            return;
        end

        idex.chk_all = 0;
        if (fl) begin
            idex.valid = 0;
        end else if (!st) begin
            idex.valid = accept;
            idex.instr = ins;
            idex.wen   = !(op == OP_STORE || op == OP_BRANCH || op == OP_ENC || ins[11:7] == 5'd0);
            idex.imm   = ref_imm(ins);
            idex.pc    = pc;
            idex.pt    = c.redirect;
            idex.jalr  = (op == OP_JALR);
        end
        reg_q.push_back(idex);

        if (in_enc) begin
            if (ool || fl) in_enc = 0;
        end else if (accept && op == OP_ENC && !ool) begin
            in_enc = 1;
        end

        if (uv) begin
            int k = int'(upc[7:2]);
            if (ut) bht[k] = (bht[k] == 3) ? 3 : bht[k] + 1;
            else    bht[k] = (bht[k] == 0) ? 0 : bht[k] - 1;
        end
    endtask

    task automatic idle();
        step(0, 32'd0, '0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic issue(logic [31:0] ins, logic [AB-1:0] pc, bit ool);
        step(0, ins, pc, 1, 0, 0, ool, 0, '0, 0);
    endtask

    task automatic train(logic [AB-1:0] upc, bit t);
        step(0, 32'd0, '0, 0, 0, 0, 0, 1, upc, t);
    endtask

    // Monitor for combinational prediction / hold outputs
    initial begin
        comb_t c;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                check("redirect", 64'(redirect_o), 64'(c.redirect));
                check("target_pc", 64'(target_pc_o), 64'(c.target));
                check("fetch_hold", 64'(fetch_hold_o), 64'(c.hold));
            end
        end
    end

    // Monitor for the registered ID/EX outputs
    initial begin
        reg_t r;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                r = reg_q.pop_front();
                check("id_valid", 64'(id_valid_o), 64'(r.valid));
                if (r.valid || r.chk_all) begin
                    check("op", 64'(op_o), 64'(r.instr[6:0]));
                    check("funct3", 64'(funct3_o), 64'(r.instr[14:12]));
                    check("funct7", 64'(funct7_o), 64'(r.instr[31:25]));
                    check("rs1", 64'(rs1_o), 64'(r.instr[19:15]));
                    check("rs2", 64'(rs2_o), 64'(r.instr[24:20]));
                    check("rd", 64'(rd_o), 64'(r.instr[11:7]));
                    check("wen", 64'(wen_o), 64'(r.wen));
                    check("imm32", 64'(imm32_o), 64'(r.imm));
                    check("pc", 64'(pc_o), 64'(r.pc));
                    check("pred_taken", 64'(pred_taken_o), 64'(r.pt));
                    check("jalr", 64'(jalr_o), 64'(r.jalr));
                end
                if (r.valid)
                    $display("txn pc=%08h instr=%08h imm=%08h wen=%0d pt=%0d jalr=%0d",
                             pc_o, {funct7_o, rs2_o, rs1_o, funct3_o, rd_o, op_o},
                             imm32_o, wen_o, pred_taken_o, jalr_o);
            end
        end
    end

    logic [6:0] op_pool [10];

    initial begin
        logic [31:0] addi;
        op_pool = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                    OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_ENC};
        addi = enc_i(12'h7ff, 5'd3, 3'd0, 5'd4, OP_IMM);

        rst_n = 0; instr_i = 0; pc_i = 0; instr_valid_i = 0; stall_i = 0;
        flush_i = 0; out_of_loop_i = 0; upd_valid_i = 0; upd_pc_i = 0; upd_taken_i = 0;
        model_reset();

        // Reset, then JAL +0x20 at 0x100
        step(1, 32'd0, '0, 0, 0, 0, 0, 0, '0, 0);
        step(1, 32'd0, '0, 0, 0, 0, 0, 0, '0, 0);
        idle();
        issue(enc_j(32'h20, 5'd1), 32'h100, 0);
        idle();

        // BEQ at 0x40 before and after training; saturation at both ends
        issue(enc_b(32'h10, 5'd1, 5'd2, 3'd0), 32'h40, 0);
        repeat (3) train(32'h40, 1);
        issue(enc_b(32'h10, 5'd1, 5'd2, 3'd0), 32'h40, 0);
        train(32'h40, 1);
        train(32'h40, 0);
        issue(enc_b(-32'sd8, 5'd1, 5'd2, 3'd1), 32'h40, 0);
        // Same-cycle read and not-taken update: read still sees the old counter
        step(0, enc_b(32'h10, 5'd1, 5'd2, 3'd0), 32'h40, 1, 0, 0, 0, 1, 32'h40, 0);
        issue(enc_b(32'h10, 5'd1, 5'd2, 3'd0), 32'h40, 0);
        repeat (4) train(32'h40, 0);
        issue(enc_b(32'h10, 5'd1, 5'd2, 3'd0), 32'h40, 0);

        // Encryption hold for 5 cycles, released by out_of_loop
        issue({25'h0, OP_ENC} | 32'h00000080, 32'h80, 0);
        repeat (5) issue(addi, 32'h84, 0);
        issue(addi, 32'h84, 1);
        issue(addi, 32'h84, 0);
        // Encryption completing in its own accept cycle stays IDLE
        issue({25'h1, OP_ENC}, 32'h88, 1);
        issue(addi, 32'h8c, 0);

        // Stall and flush together while in ENC_WAIT
        issue({25'h0, OP_ENC}, 32'h90, 0);
        step(0, addi, 32'h94, 1, 1, 1, 0, 0, '0, 0);
        issue(addi, 32'h94, 0);
        step(0, addi, 32'h98, 1, 1, 0, 0, 0, '0, 0);
        idle();

        // Immediate boundary cases
        issue({20'hABCDE, 5'd5, OP_LUI}, 32'h200, 0);
        issue(enc_i(12'h405, 5'd6, 3'd5, 5'd7, OP_IMM), 32'h204, 0);
        issue(enc_i(12'h010, 5'd1, 3'd0, 5'd0, OP_JALR), 32'h208, 0);
        issue(enc_j(-32'sd4, 5'd0), 32'h0, 0);
        issue({7'h55, 5'd9, 5'd8, 3'd2, 5'd3, OP_STORE}, 32'h20c, 0);

        // Reset during ENC_WAIT after training
        repeat (3) train(32'h40, 1);
        issue({25'h0, OP_ENC}, 32'h80, 0);
        issue(addi, 32'h84, 0);
        step(1, 32'd0, '0, 0, 0, 0, 0, 0, '0, 0);
        idle();
        issue(enc_b(32'h10, 5'd1, 5'd2, 3'd0), 32'h40, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            logic [31:0] r = $urandom;
            logic [AB-1:0] pc;
            logic [AB-1:0] upc;
            ins = {r[31:7], op_pool[$urandom_range(0, 9)]};
            pc  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                              : 32'($urandom_range(0, 255) * 4);
            upc = 32'($urandom_range(0, 255) * 4);
            step(0, ins, pc, $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 40, upc, $urandom_range(0, 1) == 1);
        end

        idle();
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drain", 64'(reg_q.size() + comb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
